// File: rtl/wide_cmp_seq_pkg.sv
// rtl/wide_cmp_seq_pkg.sv - shared types and constants for the sequential wide comparator
package wide_cmp_seq_pkg;

  // Width of one comparator slice; the shared comp4 works on one nibble at a time
  localparam int NIBBLE_W = 4;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Result encodings, bit order {eq, gt, lt}; all-zero means no result yet
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

  // Index counter width, never narrower than one bit
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/wide_cmp_seq_if.sv
// rtl/wide_cmp_seq_if.sv - request/result bundle between a datapath and the wide comparator
interface wide_cmp_seq_if #(
  parameter int NIBBLES = 4
);
  import wide_cmp_seq_pkg::*;

  localparam int W = NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic         eq;
  logic         gt;
  logic         lt;

  // Requesting datapath side
  modport master (
    output start, a, b,
    input  ready, done, eq, gt, lt
  );

  // Comparator controller side
  modport slave (
    input  start, a, b,
    output ready, done, eq, gt, lt
  );

endinterface

// File: rtl/wide_cmp_seq_comp4.sv
// rtl/wide_cmp_seq_comp4.sv - 4-bit unsigned magnitude comparator slice (one-hot eq/gt/lt)
module comp4
  import wide_cmp_seq_pkg::*;
(
  output logic                eq,
  output logic                gt,
  output logic                lt,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/wide_cmp_seq.sv
// rtl/wide_cmp_seq.sv - sequential MSB-first wide compare over one shared comp4; CMP_EARLY_EXIT_EN ends RUN at the first differing nibble
module wide_cmp_seq
  import wide_cmp_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  wide_cmp_seq_if.slave bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBBLES - 1);

  state_t             state_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [IDX_W-1:0]   idx_q;
  logic               decided_q;
  logic [2:0]         pend_q;
  logic [2:0]         res_q;
  logic               done_q;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic                c_eq;
  logic                c_gt;
  logic                c_lt;
  logic                first_diff;
  logic [2:0]          pend_d;
  logic                exit_run;

  // The shared slice always looks at the nibble selected by the walking index
  assign nib_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign nib_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

  comp4 u_comp4 (
    .eq (c_eq),
    .gt (c_gt),
    .lt (c_lt),
    .a  (nib_a),
    .b  (nib_b)
  );

  // Pending result: only the first differing nibble from the MSB may set it
  always_comb begin
    first_diff = 1'b0;
    pend_d     = pend_q;
    exit_run   = 1'b0;
    if (state_q == ST_RUN) begin
      first_diff = !c_eq && !decided_q;
      if (first_diff) begin
        pend_d = {1'b0, c_gt, c_lt};
      end
`ifdef CMP_EARLY_EXIT_EN
      exit_run = (idx_q == '0) || first_diff;
`else
      exit_run = (idx_q == '0);
`endif
    end
  end

  // Controller FSM with registered operands, index, pending and final result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      pend_q    <= RES_NONE;
      res_q     <= RES_NONE;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            a_q       <= bus.a;
            b_q       <= bus.b;
            idx_q     <= IDX_TOP;
            decided_q <= 1'b0;
            // Seeded with eq so a scan with no differing nibble needs no extra decode
            pend_q    <= RES_EQ;
            state_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          pend_q <= pend_d;
          if (first_diff) begin
            decided_q <= 1'b1;
          end
          if (exit_run) begin
            res_q   <= pend_d;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.done  = done_q;
  assign bus.eq    = res_q[2];
  assign bus.gt    = res_q[1];
  assign bus.lt    = res_q[0];

endmodule

// File: tb/tb_wide_cmp_seq.sv
// tb/tb_wide_cmp_seq.sv - scoreboard bench for wide_cmp_seq with NIBBLES=4
module tb_wide_cmp_seq;

  localparam logic [2:0] R_NONE = 3'b000;
  localparam logic [2:0] R_EQ   = 3'b100;
  localparam logic [2:0] R_GT   = 3'b010;
  localparam logic [2:0] R_LT   = 3'b001;

  typedef struct {
    logic [2:0] res;
    int         k;
    int         acc_cyc;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t sbq[$];
  exp_t mon_e;

  wide_cmp_seq_if #(.NIBBLES(4)) bus ();

  wide_cmp_seq #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 required no pulse (nothing outstanding)");
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.name, "_res"}, int'({bus.eq, bus.gt, bus.lt}), int'(mon_e.res));
        chk({mon_e.name, "_done_cycle"}, cyc - mon_e.acc_cyc + 1, mon_e.k + 1);
      end
    end
  end

  task automatic issue(input string name, input logic [15:0] av, input logic [15:0] bv,
                       input logic [2:0] res, input int k_const, input int k_early);
    int w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!bus.ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.ready) begin
      chk({name, "_ready_timeout"}, 0, 1);
      return;
    end
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    e.res     = res;
`ifdef CMP_EARLY_EXIT_EN
    e.k       = k_early;
`else
    e.k       = k_const;
`endif
    e.acc_cyc = cyc;
    e.name    = name;
    sbq.push_back(e);
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    @(negedge clk);
    while (!(bus.ready && sbq.size() == 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!(bus.ready && sbq.size() == 0)) chk({name, "_idle_timeout"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_res", int'({bus.eq, bus.gt, bus.lt}), int'(R_NONE));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", int'(bus.ready), 1);
    chk("post_rst_res", int'({bus.eq, bus.gt, bus.lt}), int'(R_NONE));

    // Directed vectors: name, a, b, result, RUN length constant / early-exit
    issue("equal",    16'hA5A5, 16'hA5A5, R_EQ, 4, 4); wait_idle("equal");
    issue("msb_diff", 16'h8000, 16'h7FFF, R_GT, 4, 1); wait_idle("msb_diff");
    issue("lsb_diff", 16'h1230, 16'h1231, R_LT, 4, 4); wait_idle("lsb_diff");
    issue("reversal", 16'h2100, 16'h1F00, R_GT, 4, 1); wait_idle("reversal");
    issue("mid_diff", 16'h0120, 16'h0130, R_LT, 4, 3); wait_idle("mid_diff");

    // Start while busy is dropped
    issue("busy", 16'h0000, 16'h0100, R_LT, 4, 2);
    chk("busy_ready_low", int'(bus.ready), 0);
    bus.start = 1'b1;
    bus.a     = 16'h0001;
    bus.b     = 16'h0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle("busy");
    chk("busy_res_kept", int'({bus.eq, bus.gt, bus.lt}), int'(R_LT));

    // Back-to-back compares with results holding in between
    issue("b2b_gt", 16'hFFFF, 16'hFFFE, R_GT, 4, 4);
    issue("b2b_eq", 16'h1234, 16'h1234, R_EQ, 4, 4);
    @(negedge clk);
    chk("hold_during_run", int'({bus.eq, bus.gt, bus.lt}), int'(R_GT));
    wait_idle("b2b");
    repeat (3) @(negedge clk);
    chk("hold_idle", int'({bus.eq, bus.gt, bus.lt}), int'(R_EQ));

    // Reset in cycle T+2 aborts the compare without a done pulse
    issue("abort", 16'h5555, 16'h5555, R_EQ, 4, 4);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("abort_ready", int'(bus.ready), 1);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_res", int'({bus.eq, bus.gt, bus.lt}), int'(R_NONE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_res_after", int'({bus.eq, bus.gt, bus.lt}), int'(R_NONE));

    issue("after_abort", 16'h0000, 16'hFFFF, R_LT, 4, 1);
    wait_idle("after_abort");

    repeat (4) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/wide_cmp_seq.md
# wide_cmp_seq

Sequential magnitude comparator for W = 4·NIBBLES-bit unsigned operands, built around one shared instance of the team's 4-bit switch-level comparator `comp4`. A start/ready/done handshake captures both operands. The controller walks the `comp4` instance from the most-significant nibble to the least, one nibble per cycle, and returns a registered one-hot eq/gt/lt result. It sits between a requesting datapath and the single comparator resource, so wide compares need no extra comparator copies.

## Interface
- NIBBLES, 4, number of 4-bit nibbles per operand (≥1); operand width W = 4·NIBBLES
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when ready=1
- a  in  W  operand A, unsigned; sampled with start
- b  in  W  operand B, unsigned; sampled with start
- ready  out  1  high only in IDLE; combinational from state
- done  out  1  one-cycle pulse, result valid
- eq  out  1  registered, A==B
- gt  out  1  registered, A>B
- lt  out  1  registered, A<B

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready=1. If start=1 at an edge:
  - latch a→a_q and b→b_q
  - idx←NIBBLES-1, decided←0
  - go to RUN
- RUN: `comp4` receives a_q[4·idx+:4] and b_q[4·idx+:4]. Its eq/gt/lt outputs are evaluated combinationally within the cycle.
  - Nibble not equal and decided=0: capture gt/lt into the pending result and set decided←1.
  - The first differing nibble, scanning from the MSB, always determines the result. Later nibbles never overwrite it.
  - If idx==0, or an exit is permitted (see Configuration): go to DONE. If no nibble differed, the pending result is eq.
  - Otherwise idx←idx-1.
- DONE:
  - done=1 for exactly this cycle.
  - eq/gt/lt are loaded at the RUN→DONE edge.
  - Go to IDLE unconditionally.
- eq/gt/lt are exactly one-hot after the first completed compare. They hold their value until the next RUN→DONE edge.
- start while ready=0 is ignored, not queued.
- a/b may change freely after the accepting edge.

## Timing
- Reset (async assert, rst_n low): state=IDLE, ready=1, done=0, eq=gt=lt=0 (all zero = no result yet), idx=0, decided=0, a_q=b_q=0.
- Reset asserted mid-RUN or in DONE: the operation aborts. No done pulse is produced and outputs return to reset values.
- Reset deassertion takes effect at the next clock edge. Drive it synchronously deasserted at the integration level.
- Start accepted at edge T: RUN occupies cycles T+1 … T+k, done is high in cycle T+k+1, ready returns in cycle T+k+2.
  - Without early exit: k=NIBBLES.
  - With early exit: k = position of the first differing nibble counted from the MSB (1…NIBBLES).
  - Worst-case latency is NIBBLES+1 cycles from the accepting edge to done. Throughput is one compare per NIBBLES+2 cycles.
- NIBBLES=1: RUN lasts exactly one cycle in both configurations.
- idx width is $clog2(NIBBLES), minimum 1. idx never wraps below 0, because DONE is taken at idx==0.

## Configuration
- CMP_EARLY_EXIT_EN defined: RUN→DONE is taken in the same cycle that decided is set, i.e. at the first non-equal nibble. Latency therefore depends on the data.
- CMP_EARLY_EXIT_EN undefined: RUN always lasts NIBBLES cycles, giving constant latency NIBBLES+1 for timing-predictable consumers.
- The result is identical in both configurations.

## Structure
- Package `wide_cmp_seq_pkg`:
  - state enum (IDLE, RUN, DONE)
  - constant NIBBLE_W=4
  - result encoding constants for {eq,gt,lt}
- Sub-module: a single instance of `comp4`, port order (eq, gt, lt, a, b). The FSM, index counter and result registers live in wide_cmp_seq itself; no further hierarchy.

## Test plan
- Reset check: assert rst_n=0 → ready=1, done=0, eq=gt=lt=0; release → still idle, no done pulse.
- Equal operands: NIBBLES=4, a=16'hA5A5, b=16'hA5A5, start → eq=1 and done in cycle T+5 in both configurations.
- MSB difference: a=16'h8000, b=16'h7FFF → gt=1. Done at T+2 with CMP_EARLY_EXIT_EN, at T+5 without.
- LSB difference: a=16'h1230, b=16'h1231 → lt=1, done at T+5 in both configurations. Also confirm a later-nibble reversal is ignored: a=16'h2100, b=16'h1F00 → gt=1.
- Busy handling: pulse start with a=16'h0001, b=16'h0000 during RUN → ignored, first result unchanged. Back-to-back starts are accepted when ready=1, and eq/gt/lt hold between compares.
- Reset mid-operation: assert rst_n in cycle T+2 of a compare → no done pulse, outputs zero. A fresh compare (a=16'h0000, b=16'hFFFF) then gives lt=1.
